mem_loader: RTL

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/loader_pkg.sv | 18 +
 rtl/mem_loader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the framed byte-stream memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    LEN_HI  = 3'd3,
    LEN_LO  = 3'd4,
    DATA    = 3'd5,
    CSUM    = 3'd6,
    DONE    = 3'd7
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         LEN_W        = 12;

endpackage

// File: rtl/mem_loader.sv
// Parses SYNC/ADDR/LEN/DATA/CSUM frames from a byte stream and writes the
// payload into an external byte memory, flagging checksum mismatches.
//
// state   | meaning
// IDLE    | hunting for SYNC, other bytes dropped
// ADDR_HI | expecting start address high byte
// ADDR_LO | expecting start address low byte
// LEN_HI  | expecting length high nibble (upper nibble ignored)
// LEN_LO  | expecting length low byte
// DATA    | payload bytes, one memory write each
// CSUM    | expecting XOR checksum byte
// DONE    | one-cycle end-of-frame pulse, input stalled
module mem_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W = 11,
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         hi_q, hi_d;
  logic               err_q, err_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  maddr_q, maddr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && in_data == SYNC) state_d = ADDR_HI;
      ADDR_HI: if (accept) state_d = ADDR_LO;
      ADDR_LO: if (accept) state_d = LEN_HI;
      LEN_HI:  if (accept) state_d = LEN_LO;
      LEN_LO:  if (accept) state_d = ({rem_q[LEN_W-1:8], in_data} != '0) ? DATA : CSUM;
      DATA:    if (accept && rem_q == LEN_W'(1)) state_d = CSUM;
      CSUM:    if (accept) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: header capture, running checksum and registered write strobe.
  always_comb begin
    addr_d  = addr_q;
    rem_d   = rem_q;
    csum_d  = csum_q;
    hi_d    = hi_q;
    err_d   = err_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    if (accept) begin
      case (state_q)
        IDLE:    csum_d = '0;
        ADDR_HI: begin
          hi_d   = in_data;
          csum_d = csum_q ^ in_data;
        end
        ADDR_LO: begin
          addr_d = ADDR_W'({hi_q, in_data});
          csum_d = csum_q ^ in_data;
        end
        LEN_HI:  begin
          rem_d  = {in_data[3:0], 8'h00};
          csum_d = csum_q ^ in_data;
        end
        LEN_LO:  begin
          rem_d  = {rem_q[LEN_W-1:8], in_data};
          csum_d = csum_q ^ in_data;
        end
        DATA:    begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = in_data;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          csum_d  = csum_q ^ in_data;
        end
        CSUM:    err_d = (in_data != csum_q);
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    in_ready = (state_q != DONE);
  end

  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;

endmodule
